spi_master: RTL and testbench
=============================

# spi_master

Single-clock SPI master that issues 10-bit command frames to the team's SPI slave and collects 8-bit read data from MISO. It sits between a register/command agent (parallel `cmd_data` + `start` handshake) and the serial `SS_n`/`MOSI`/`MISO` pins. `SS_n` and `MOSI` are driven synchronously to `clk`, and the slave samples them on the same edge domain. It also tracks the read-address/read-data pairing rule of the slave protocol.

## Interface
- `TURNAROUND`, default 2: cycles between the last command bit and the first MISO sample in a read-data frame (1..7).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `cmd_data`  in  10  frame. `[9:8]` is the opcode: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data. `[7:0]` is the payload.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse at frame end.
- `rd_data`  out  8  read byte; held until the next read-data frame completes.
- `rd_valid`  out  1  one-cycle pulse coincident with `done` on read-data frames.
- `proto_err`  out  1  one-cycle pulse with `done` when a read-data frame is issued with no pending read-addr.
- `SS_n`  out  1  slave select, active low.
- `MOSI`  out  1  serial data to the slave, MSB first.
- `MISO`  in  1  serial data from the slave, LSB first.

## Operation
- States:
  - IDLE
  - CMD: guard bit; `MOSI`=`cmd[9]` so the slave can pick its branch.
  - SHIFT: 10 cycles.
  - TURN: `TURNAROUND` cycles.
  - READ: 8 cycles.
  - END
- Transitions:
  - IDLE→CMD on accepted `start`.
  - CMD→SHIFT.
  - SHIFT→END after bit 0, when opcode≠11.
  - SHIFT→TURN after bit 0, when opcode=11.
  - TURN→READ.
  - READ→END after 8 samples.
  - END→IDLE.
- `cmd_data` is latched into a 10-bit shift register on accept. Later changes on the input are ignored.
- SHIFT drives `MOSI`=`sh[9]` and shifts left by one each cycle.
- In TURN, READ and END, `MOSI`=0.
- READ samples `MISO` into `rd_data` bit k on the k-th READ cycle (k=0..7). This sampling uses a staging register; `rd_data` updates only in END.
- Pending read-addr flag:
  - Set on completion of an opcode-10 frame.
  - Cleared on completion of an opcode-11 frame.
  - Unaffected by opcode 00/01.
- An opcode-11 frame with the flag clear is still executed in full. `proto_err` pulses in its END cycle.
- Reset values: `SS_n`=1, `MOSI`=0, `busy`=0, `done`=0, `rd_valid`=0, `proto_err`=0, `rd_data`=0, flag=0, state IDLE.
- Reset mid-frame returns all of the above to reset values immediately (asynchronously). No `done` pulse is produced for the aborted frame.

## Timing
- `start` sampled high at edge T while `busy`=0 → `busy`=1 and `SS_n`=0 from T+1 (CMD).
- `MOSI` carries `cmd[9]` in cycles T+1 and T+2, then `cmd[8]`…`cmd[0]` in cycles T+3..T+11.
- Write frames and read-addr frames: END at T+12. In END, `SS_n`=1, `done`=1 and `busy`=1. `busy`=0 from T+13.
- Read-data frames:
  - TURN occupies T+12..T+11+`TURNAROUND`.
  - READ occupies the next 8 cycles.
  - END follows; total = 20+`TURNAROUND` cycles from T to END.
- `SS_n` is high for at least one cycle (END) between back-to-back frames. The earliest next accept is the first IDLE cycle after END.
- `start` while `busy`=1 is dropped, not queued.
- `start` held high continuously produces back-to-back frames, each separated by END+IDLE (minimum 2 cycles of `SS_n`=1).

## Structure
- Shared package `spi_pkg`:
  - opcode constants: `OP_WR_ADDR`, `OP_WR_DATA`, `OP_RD_ADDR`, `OP_RD_DATA`
  - `FRAME_W`=10
  - `DATA_W`=8
  - master state encoding
- The slave imports the same opcodes.
- Single module; no sub-module.
- Counter: 4-bit unsigned, reused across SHIFT/TURN/READ, reloaded on each state entry.

## Test plan
- Write-addr: reset, then `start` with `cmd_data`=10'h0A5 → `SS_n` low for 11 cycles, `MOSI` sequence 0,0,0,1,0,1,0,0,1,0,1, then `done` at T+12; `rd_valid`=0.
- Read pair:
  - Send 10'h212, then 10'h300 with the slave model returning 8'h3C on `MISO` LSB-first after `TURNAROUND`=2.
  - Required response: `rd_data`=8'h3C, with `rd_valid` and `done` together at T+22; `proto_err`=0.
- Orphan read: 10'h3FF without a prior read-addr → full frame executes and `proto_err` pulses with `done`. A following 10'h3FF pulses `proto_err` again.
- Busy drop: pulse `start` with 10'h155 at T+5 of an active frame → ignored. Exactly one `done` is observed; the `MOSI` pattern matches the first command only.
- Reset abort: assert `rst_n`=0 at T+7 of a write frame → `SS_n`=1 and `MOSI`=0 immediately; no `done`. After release, a new 10'h1FF frame completes normally.
- Back-to-back: hold `start`=1 with 10'h0FF → consecutive frames, with `SS_n` high for exactly 2 cycles between them.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame opcodes, frame/data widths and master state encoding.
// The slave imports the same opcode constants.
package spi_pkg;

    localparam int unsigned FRAME_W = 10;
    localparam int unsigned DATA_W  = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_SHIFT = 3'd2,
        S_TURN  = 3'd3,
        S_READ  = 3'd4,
        S_END   = 3'd5
    } mst_state_e;

endpackage

// File: rtl/spi_master.sv
// SPI master: sends 10-bit command frames MSB first with a leading guard bit and,
// for read-data frames, collects 8 MISO bits LSB first after a turnaround gap.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned TURNAROUND = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] cmd_data,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               proto_err,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    mst_state_e         state_q;
    logic [FRAME_W-1:0] sh_q;
    logic [1:0]         op_q;
    logic [3:0]         cnt_q;
    logic [DATA_W-2:0]  stage_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               pend_q;
    logic               busy_q;
    logic               done_q;
    logic               rd_valid_q;
    logic               proto_err_q;
    logic               ss_n_q;
    logic               mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            op_q        <= OP_WR_ADDR;
            cnt_q       <= '0;
            stage_q     <= '0;
            rd_data_q   <= '0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_CMD;
                        sh_q    <= cmd_data;
                        op_q    <= cmd_data[FRAME_W-1:FRAME_W-2];
                        busy_q  <= 1'b1;
                        ss_n_q  <= 1'b0;
                        mosi_q  <= cmd_data[FRAME_W-1];
                    end
                end
                S_CMD: begin
                    // Guard bit repeats cmd[9]; the shift starts here so SHIFT opens on cmd[8].
                    mosi_q  <= sh_q[FRAME_W-1];
                    sh_q    <= {sh_q[FRAME_W-2:0], 1'b0};
                    cnt_q   <= 4'd9;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (cnt_q == 4'd0) begin
                        mosi_q <= 1'b0;
                        if (op_q == OP_RD_DATA) begin
                            state_q <= S_TURN;
                            cnt_q   <= 4'(TURNAROUND - 1);
                        end else begin
                            state_q <= S_END;
                            ss_n_q  <= 1'b1;
                            done_q  <= 1'b1;
                            if (op_q == OP_RD_ADDR) begin
                                pend_q <= 1'b1;
                            end
                        end
                    end else begin
                        mosi_q <= sh_q[FRAME_W-1];
                        sh_q   <= {sh_q[FRAME_W-2:0], 1'b0};
                        cnt_q  <= cnt_q - 4'd1;
                    end
                end
                S_TURN: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_READ;
                        cnt_q   <= 4'(DATA_W - 1);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_READ: begin
                    // Final sample goes straight into rd_data so the byte is visible in END.
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_END;
                        rd_data_q   <= {MISO, stage_q};
                        ss_n_q      <= 1'b1;
                        done_q      <= 1'b1;
                        rd_valid_q  <= 1'b1;
                        proto_err_q <= ~pend_q;
                        pend_q      <= 1'b0;
                    end else begin
                        stage_q <= {MISO, stage_q[DATA_W-2:1]};
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                S_END: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ss_n_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign proto_err = proto_err_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes expected frame results,
// a negedge monitor pops and checks them on every done pulse.
module tb_spi_master;
    import spi_pkg::*;

    localparam int TA = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [9:0] cmd_data = '0;
    logic       busy, done, rd_valid, proto_err, SS_n, MOSI;
    logic       MISO = 1'b0;
    logic [7:0] rd_data;

    spi_master #(.TURNAROUND(TA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .done      (done),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .proto_err (proto_err),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  cmd;
        int          busy_cyc;
        int          low_cyc;
        logic [10:0] mosi;
        logic        rv;
        logic        pe;
        logic [7:0]  rd;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad = 0;
    int         n_done = 0;
    int         last_gap = 0;
    logic [7:0] miso_byte = '0;
    logic [7:0] model_rd = '0;
    logic       model_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [9:0] cmd, input logic [7:0] mb);
        exp_t e;
        e.cmd  = cmd;
        e.mosi = {cmd[9], cmd};
        e.rv   = (cmd[9:8] == OP_RD_DATA);
        e.pe   = e.rv && !model_pend;
        if (e.rv) begin
            model_rd   = mb;
            model_pend = 1'b0;
            e.busy_cyc = 20 + TA;
            e.low_cyc  = 19 + TA;
        end else begin
            if (cmd[9:8] == OP_RD_ADDR) model_pend = 1'b1;
            e.busy_cyc = 12;
            e.low_cyc  = 11;
        end
        e.rd = model_rd;
        sbq.push_back(e);
    endtask

    // Returns at the negedge of cycle T+1 (T = accepting edge).
    task automatic send(input logic [9:0] cmd, input logic [7:0] mb, input bit expect_done);
        int g = 0;
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (busy) chk("send_wait_idle", 32'(busy), 32'd0);
        miso_byte = mb;
        if (expect_done) push_exp(cmd, mb);
        start    = 1'b1;
        cmd_data = cmd;
        @(negedge clk);
        start    = 1'b0;
        cmd_data = ~cmd;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while ((sbq.size() != 0 || busy) && g < 400) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (sbq.size() != 0 || busy) begin
            bad++;
            $display("FAIL timeout_%s: pending=%0d busy=%0b want pending=0 busy=0", tag, sbq.size(), busy);
        end
    endtask

    // Slave model: drives the byte LSB first during the READ window, 1s elsewhere.
    initial begin
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!SS_n) begin
                if (n >= 11 + TA && n < 19 + TA) MISO = miso_byte[n - 11 - TA];
                else MISO = 1'b1;
                n++;
            end else begin
                n = 0;
                MISO = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        int          m_busy, m_low, m_high;
        logic [10:0] m_mosi;
        logic        m_tail, prev_ss;
        exp_t        e;
        m_busy = 0; m_low = 0; m_high = 0; m_mosi = '0; m_tail = 1'b0; prev_ss = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_low = 0; m_high = 0; m_mosi = '0; m_tail = 1'b0; prev_ss = 1'b1;
            end else begin
                if (busy) m_busy++;
                if (!SS_n) begin
                    if (prev_ss) begin
                        last_gap = m_high;
                        m_high = 0;
                    end
                    if (m_low < 11) m_mosi = {m_mosi[9:0], MOSI};
                    else if (MOSI) m_tail = 1'b1;
                    m_low++;
                end else begin
                    m_high++;
                end
                prev_ss = SS_n;
                if (done) begin
                    n_done++;
                    if (sbq.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("busy_cycles", 32'(m_busy), 32'(e.busy_cyc));
                        chk("ssn_low_cycles", 32'(m_low), 32'(e.low_cyc));
                        chk("mosi_bits", 32'(m_mosi), 32'(e.mosi));
                        chk("mosi_tail_zero", 32'(m_tail), 32'd0);
                        chk("end_ssn", 32'(SS_n), 32'd1);
                        chk("end_busy", 32'(busy), 32'd1);
                        chk("end_mosi", 32'(MOSI), 32'd0);
                        chk("rd_valid", 32'(rd_valid), 32'(e.rv));
                        chk("proto_err", 32'(proto_err), 32'(e.pe));
                        chk("rd_data", 32'(rd_data), 32'(e.rd));
                    end
                    m_busy = 0; m_low = 0; m_mosi = '0; m_tail = 1'b0;
                end else if (rd_valid || proto_err) begin
                    chk("pulse_without_done", {30'd0, rd_valid, proto_err}, 32'd0);
                end
            end
        end
    end

    initial begin
        int d0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ssn", 32'(SS_n), 32'd1);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write-addr: MOSI 0,0,0,1,0,1,0,0,1,0,1
        send(10'h0A5, 8'h00, 1'b1);
        wait_idle("wr_addr");

        // Read pair
        send(10'h212, 8'h00, 1'b1);
        send(10'h300, 8'h3C, 1'b1);
        wait_idle("rd_pair");
        chk("rd_pair_byte", 32'(rd_data), 32'h3C);

        // Orphan reads
        send(10'h3FF, 8'hA5, 1'b1);
        send(10'h3FF, 8'h5A, 1'b1);
        wait_idle("orphan");
        chk("orphan_byte", 32'(rd_data), 32'h5A);

        // Busy drop
        d0 = n_done;
        send(10'h0C3, 8'h00, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        cmd_data = 10'h155;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_drop");
        repeat (20) @(negedge clk);
        chk("busy_drop_done_count", 32'(n_done - d0), 32'd1);

        // Reset abort with a read-addr pending
        send(10'h2AA, 8'h00, 1'b1);
        wait_idle("pre_abort");
        d0 = n_done;
        send(10'h055, 8'h00, 1'b0);
        repeat (6) @(negedge clk);
        chk("abort_pre_mosi", 32'(MOSI), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ssn", 32'(SS_n), 32'd1);
        chk("abort_mosi", 32'(MOSI), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        model_pend = 1'b0;
        model_rd   = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        chk("abort_rd_data", 32'(rd_data), 32'd0);
        send(10'h1FF, 8'h00, 1'b1);
        send(10'h300, 8'h81, 1'b1);
        wait_idle("post_abort");

        // Back-to-back: three frames with start held high
        d0 = n_done;
        push_exp(10'h0FF, 8'h00);
        push_exp(10'h0FF, 8'h00);
        push_exp(10'h0FF, 8'h00);
        start = 1'b1;
        cmd_data = 10'h0FF;
        repeat (30) @(negedge clk);
        start = 1'b0;
        wait_idle("b2b");
        chk("b2b_done_count", 32'(n_done - d0), 32'd3);
        chk("b2b_ssn_gap", 32'(last_gap), 32'd2);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
